// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : RV32I decode stage and ID/EX pipeline register. Drives the
//                register file read ports from IF/ID, decodes immediates and
//                control bits, detects load-use hazards (one bubble), and
//                honours downstream stall and branch flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  // IF/ID
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  // Register file read port
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  input  logic [31:0] rf_data1,
  input  logic [31:0] rf_data2,
  // Downstream control
  input  logic        ex_stall,
  input  logic        ex_flush,
  output logic        stall_if,
  // ID/EX register
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_rs1_data,
  output logic [31:0] id_rs2_data,
  output logic [31:0] id_imm,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [4:0]  id_rd,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3,
  output logic        id_funct7b5,
  output logic        id_reg_write,
  output logic        id_mem_read,
  output logic        id_mem_write,
  output logic        id_illegal
);

  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OP_OP     = 7'b0110011;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic        w_rd_nz;
  logic        w_uses_rs1;
  logic        w_uses_rs2;
  logic [31:0] w_imm;
  logic        w_reg_write;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_illegal;
  logic        w_hazard;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;

  assign w_opcode = if_inst[6:0];
  assign w_rd     = if_inst[11:7];
  assign w_rd_nz  = (w_rd != 5'd0);

  // Register file addresses come straight from the instruction word.
  assign rf_rs1 = if_inst[19:15];
  assign rf_rs2 = if_inst[24:20];

  // x0 always reads as zero, whatever the register file returns.
  assign w_rs1_data = (rf_rs1 == 5'd0) ? 32'd0 : rf_data1;
  assign w_rs2_data = (rf_rs2 == 5'd0) ? 32'd0 : rf_data2;

  // Opcode decode: operand usage, immediate format and control bits.
  always_comb begin
    w_uses_rs1  = 1'b1;
    w_uses_rs2  = 1'b0;
    w_imm       = 32'd0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_illegal   = 1'b0;
    case (w_opcode)
      c_OP_LUI, c_OP_AUIPC: begin
        w_uses_rs1  = 1'b0;
        w_imm       = {if_inst[31:12], 12'd0};
        w_reg_write = w_rd_nz;
      end
      c_OP_JAL: begin
        w_uses_rs1  = 1'b0;
        w_imm       = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                       if_inst[20], if_inst[30:21], 1'b0};
        w_reg_write = w_rd_nz;
      end
      c_OP_JALR, c_OP_OPIMM: begin
        w_imm       = {{20{if_inst[31]}}, if_inst[31:20]};
        w_reg_write = w_rd_nz;
      end
      c_OP_LOAD: begin
        w_imm       = {{20{if_inst[31]}}, if_inst[31:20]};
        w_reg_write = w_rd_nz;
        w_mem_read  = 1'b1;
      end
      c_OP_STORE: begin
        w_uses_rs2  = 1'b1;
        w_imm       = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
        w_mem_write = 1'b1;
      end
      c_OP_BRANCH: begin
        w_uses_rs2  = 1'b1;
        w_imm       = {{19{if_inst[31]}}, if_inst[31], if_inst[7],
                       if_inst[30:25], if_inst[11:8], 1'b0};
      end
      c_OP_OP: begin
        w_uses_rs2  = 1'b1;
        w_reg_write = w_rd_nz;
      end
      default: begin
        w_illegal   = 1'b1;
      end
    endcase
  end

  // A load sitting in ID/EX whose destination is needed by IF/ID cannot be
  // forwarded in time, so one bubble is inserted.
  assign w_hazard = if_valid & id_valid & id_mem_read & (id_rd != 5'd0) &
                    ((w_uses_rs1 & (rf_rs1 == id_rd)) |
                     (w_uses_rs2 & (rf_rs2 == id_rd)));

  // A flush kills the load that caused the hazard, so the hazard stall drops.
  assign stall_if = ex_stall | (w_hazard & ~ex_flush);

  // ID/EX register: flush > stall > hazard bubble > capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || ex_flush || (!ex_stall && w_hazard)) begin
      id_valid     <= 1'b0;
      id_pc        <= 32'd0;
      id_rs1_data  <= 32'd0;
      id_rs2_data  <= 32'd0;
      id_imm       <= 32'd0;
      id_rs1       <= 5'd0;
      id_rs2       <= 5'd0;
      id_rd        <= 5'd0;
      id_opcode    <= 7'd0;
      id_funct3    <= 3'd0;
      id_funct7b5  <= 1'b0;
      id_reg_write <= 1'b0;
      id_mem_read  <= 1'b0;
      id_mem_write <= 1'b0;
      id_illegal   <= 1'b0;
    end else if (!ex_stall) begin
      id_valid     <= if_valid;
      id_pc        <= if_pc;
      id_rs1_data  <= w_rs1_data;
      id_rs2_data  <= w_rs2_data;
      id_imm       <= w_imm;
      id_rs1       <= rf_rs1;
      id_rs2       <= rf_rs2;
      id_rd        <= w_rd;
      id_opcode    <= w_opcode;
      id_funct3    <= if_inst[14:12];
      id_funct7b5  <= if_inst[30];
      id_reg_write <= if_valid & w_reg_write;
      id_mem_read  <= if_valid & w_mem_read;
      id_mem_write <= if_valid & w_mem_write;
      id_illegal   <= if_valid & w_illegal;
    end
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

Decode stage and ID/EX pipeline register of the five-stage RV32I core. It drives the register file read addresses from the IF/ID instruction and captures the operands returned by the register file. It also decodes the immediate and control bits, and holds them for EX. Load-use hazards are detected here by inserting one bubble, and the stage honours downstream stall and branch flush.

## Interface
- No parameters; widths fixed: DATA 32, REGS 5.
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- if_valid  in  1  IF/ID holds a live instruction
- if_pc  in  32  PC of IF/ID instruction
- if_inst  in  32  IF/ID instruction word
- rf_rs1, rf_rs2  out  5  register file read addresses, combinational = if_inst[19:15], if_inst[24:20]
- rf_data1, rf_data2  in  32  register file read data (combinational from rf_rs1/rf_rs2)
- ex_stall  in  1  downstream busy; hold ID/EX contents
- ex_flush  in  1  branch/jump resolved taken in EX; kill the instruction being captured
- stall_if  out  1  hold PC and IF/ID this cycle
- id_valid  out  1  ID/EX holds a live instruction
- id_pc  out  32  captured PC
- id_rs1_data, id_rs2_data  out  32  captured operands
- id_imm  out  32  sign-extended immediate
- id_rs1, id_rs2, id_rd  out  5  captured register indices
- id_opcode  out  7, id_funct3  out  3, id_funct7b5  out  1  raw fields for ALU control
- id_reg_write, id_mem_read, id_mem_write, id_illegal  out  1  control bits

## Operation
- Decode (combinational on if_inst):
  - uses_rs1 is 1 unless the opcode is LUI, AUIPC or JAL.
  - uses_rs2 is 1 for OP (0110011), STORE (0100011) and BRANCH (1100011).
  - The immediate covers the I, S, B, U and J formats. All formats sign-extend from inst[31]. B and J set bit 0 to 0. U is inst[31:12]<<12. R-type gives 0.
  - reg_write is 1 for OP, OP-IMM, LOAD, JAL, JALR, LUI and AUIPC, and only when rd != 0.
  - mem_read is 1 for LOAD; mem_write is 1 for STORE.
  - Any other opcode sets illegal=1 and clears all other controls.
- Operand capture: if the rs index is 0, the captured data is 0 regardless of rf_data.
- The register file writes on negedge, so a WB write and an ID read of the same register in the same cycle capture the new value. No WB-to-ID bypass exists here.
- Load-use hazard = if_valid & id_valid & id_mem_read & (id_rd != 0) & ((uses_rs1 & rs1 == id_rd) | (uses_rs2 & rs2 == id_rd)).
- stall_if = ex_stall | (hazard & ~ex_flush).
- Posedge update priority: rst > ex_flush > ex_stall > hazard > capture.
  - ex_flush: load a bubble (id_valid=0; reg_write, mem_read, mem_write, illegal = 0). Data fields are don't-care; they are zeroed.
  - ex_stall: hold all ID/EX registers unchanged.
  - hazard: load a bubble. IF/ID is held by stall_if.
  - capture: id_valid <= if_valid. Controls are loaded only if if_valid, else they are 0. All fields are loaded.
- A bubble clears id_valid, so the hazard drops the next cycle and the held instruction is captured. The stall is exactly one cycle.

## Timing
- Reset values: every id_* output is 0, including id_pc and id_imm. stall_if equals ex_stall during and after reset, because id_valid=0.
- rf_rs1/rf_rs2 are purely combinational and unaffected by rst.
- Latency: one cycle, IF/ID to ID/EX outputs.
- Throughput: one instruction per cycle absent hazard or stall.
- ex_flush and ex_stall together: flush wins, and ID/EX becomes a bubble. stall_if still follows ex_stall.
- Hazard and ex_flush together: flush wins and stall_if=0. The stale load in EX is being killed.
- A hazard while if_valid=0 cannot occur (it is gated by if_valid).
- rst asserted mid-stall: outputs clear immediately (asynchronously). On release the stage is empty.

## Test plan
- Reset: assert rst with if_valid=1 and a live instruction applied → all id_* = 0 immediately. After release, addi x1,x0,5 (0x00500093) yields next cycle id_valid=1, id_imm=5, id_rd=1, id_reg_write=1, id_rs1_data=0.
- Load-use: lw x5,0(x2), then add x6,x5,x3 → one cycle with stall_if=1 and an id_valid=0 bubble. The add is then captured with id_rs1=5. Replacing rs1 with x0 or x7 → no stall.
- Write/read same cycle: WB writes x4=0xDEADBEEF at negedge while ID reads x4 → id_rs1_data=0xDEADBEEF at the following posedge.
- Immediates:
  - beq x0,x0,-4 (0xFE000EE3) → id_imm=0xFFFFFFFC.
  - jal x1,2048 (0x001000EF with imm bit 11) → 0x00000800.
  - lui x3,0xABCDE → 0xABCDE000.
  - sw → S-format immediate and id_mem_write=1, id_reg_write=0.
- Stall/flush: hold ex_stall 3 cycles → ID/EX is unchanged and stall_if=1. Assert ex_flush together with ex_stall and a load-use hazard → bubble next cycle and stall_if follows ex_stall only.
- Illegal and x0: opcode 0x7F → id_illegal=1 with all other controls 0. addi x0,x0,1 → id_reg_write=0.
